sprite_blitter: RTL and testbench



---
 rtl/sprite_blitter.sv | 176 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - Chip-8 DRW sprite blitter with read-modify-write XOR into a 64x32 framebuffer
// Optional build macro: SPRITE_CLIP_EN (clip at right/bottom edges instead of wrapping).
module sprite_blitter #(
  parameter int MEM_AW = 12,
  parameter int FB_AW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [7:0]        vx,
  input  logic [7:0]        vy,
  input  logic [3:0]        n,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              fb_en,
  output logic              fb_write,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_RDL,
    S_RDR,
    S_WRL,
    S_WRR,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [MEM_AW-1:0] base;
  logic [5:0]        x;
  logic [4:0]        y;
  logic [3:0]        n_r;
  logic [3:0]        row;
  logic [7:0]        sprite;
  logic [7:0]        left;
  logic [7:0]        right;

  logic [2:0]  xb;
  logic [2:0]  xo;
  logic [2:0]  xb1;
  logic [4:0]  yr;
  logic [15:0] mask;
  logic [7:0]  hi;
  logic [7:0]  lo;
  logic        left_ok;
  logic        right_ok;
  logic        last_row;
  logic        unused_bits;

  assign unused_bits = ^{vx[7:6], vy[7:5]};

  assign xb   = x[5:3];
  assign xo   = x[2:0];
  assign xb1  = xb + 3'd1;
  assign yr   = y + {1'b0, row};
  assign mask = {sprite, 8'h00} >> xo;
  assign hi   = mask[15:8];
  assign lo   = mask[7:0];
  assign last_row = (row == (n_r - 4'd1));

`ifdef SPRITE_CLIP_EN
  // Rows past the bottom edge and the byte past the right edge are dropped.
  logic row_vis;
  assign row_vis  = ({1'b0, y} + {2'b00, row}) < 6'd32;
  assign left_ok  = row_vis;
  assign right_ok = row_vis && (xo != 3'd0) && (xb != 3'd7);
`else
  assign left_ok  = 1'b1;
  assign right_ok = (xo != 3'd0);
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      base      <= '0;
      x         <= '0;
      y         <= '0;
      n_r       <= '0;
      row       <= '0;
      sprite    <= '0;
      left      <= '0;
      right     <= '0;
      collision <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            base      <= i_addr;
            x         <= vx[5:0];
            y         <= vy[4:0];
            n_r       <= n;
            row       <= '0;
            collision <= 1'b0;
          end
        end
        S_RDL: sprite <= mem_data;
        S_RDR: left   <= fb_rdata;
        S_WRL: begin
          right <= fb_rdata;
          if (left_ok) collision <= collision | (|(left & hi));
        end
        S_WRR: begin
          if (right_ok) collision <= collision | (|(right & lo));
          row <= row + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Address/data outputs are forced to zero whenever their enable is low.
  always_comb begin
    state_n  = state;
    mem_en   = 1'b0;
    mem_addr = '0;
    fb_en    = 1'b0;
    fb_write = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    case (state)
      S_IDLE: begin
        if (start) state_n = (n == 4'd0) ? S_DONE : S_MEM;
      end
      S_MEM: begin
        mem_en   = 1'b1;
        mem_addr = base + MEM_AW'(row);
        state_n  = S_RDL;
      end
      S_RDL: begin
        fb_en   = 1'b1;
        fb_addr = FB_AW'({yr, xb});
        state_n = S_RDR;
      end
      S_RDR: begin
        fb_en   = 1'b1;
        fb_addr = FB_AW'({yr, xb1});
        state_n = S_WRL;
      end
      S_WRL: begin
        if (left_ok) begin
          fb_en    = 1'b1;
          fb_write = 1'b1;
          fb_addr  = FB_AW'({yr, xb});
          fb_wdata = left ^ hi;
        end
        state_n = S_WRR;
      end
      S_WRR: begin
        if (right_ok) begin
          fb_en    = 1'b1;
          fb_write = 1'b1;
          fb_addr  = FB_AW'({yr, xb1});
          fb_wdata = right ^ lo;
        end
        state_n = last_row ? S_DONE : S_MEM;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed self-checking bench for sprite_blitter
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] i_addr = '0;
  logic [7:0]  vx = '0;
  logic [7:0]  vy = '0;
  logic [3:0]  n = '0;
  logic        busy, done, collision;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        fb_en, fb_write;
  logic [7:0]  fb_addr, fb_wdata, fb_rdata;

  logic [7:0] mem [0:4095];
  logic [7:0] fb  [0:255];
  logic       fb_clr = 1'b0;
  int mem_cnt = 0, fben_cnt = 0, fbw_cnt = 0, done_cnt = 0;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  sprite_blitter #(.MEM_AW(12), .FB_AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .i_addr(i_addr),
    .vx(vx), .vy(vy), .n(n), .busy(busy), .done(done),
    .collision(collision), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .fb_en(fb_en), .fb_write(fb_write),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) mem_data <= mem[mem_addr];
    if (fb_clr) begin
      for (int i = 0; i < 256; i++) fb[i] <= 8'h00;
    end else if (fb_en && fb_write) begin
      fb[fb_addr] <= fb_wdata;
    end else if (fb_en) begin
      fb_rdata <= fb[fb_addr];
    end
    if (mem_en) mem_cnt <= mem_cnt + 1;
    if (fb_en) fben_cnt <= fben_cnt + 1;
    if (fb_en && fb_write) fbw_cnt <= fbw_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic draw(input logic [11:0] a, input logic [7:0] x, input logic [7:0] y,
                      input logic [3:0] h, output int lat);
    @(negedge clk);
    i_addr = a; vx = x; vy = y; n = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, m0, e0, w0, d0;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'hF0;
    mem[12'h210] = 8'hFF;
    mem[12'h220] = 8'hC3;
    mem[12'h221] = 8'hC3;
    mem[12'h230] = 8'h00;
    mem[12'hFFF] = 8'h80;
    mem[12'h000] = 8'h01;
    mem[12'h240] = 8'hAA;
    mem[12'h241] = 8'h55;
    mem[12'h242] = 8'hFF;

    fb_clr = 1'b1;
    repeat (3) @(negedge clk);
    fb_clr = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coll", collision, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_fb_en", fb_en, 0);
    check("rst_fb_write", fb_write, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // Single byte at origin
    w0 = fbw_cnt;
    draw(12'h200, 8'd0, 8'd0, 4'd1, lat);
    check("t1_lat", lat, 6);
    check("t1_coll", collision, 0);
    check("t1_fb00", fb[8'h00], 8'hF0);
    check("t1_writes", fbw_cnt - w0, 1);
    check("t1_fb01", fb[8'h01], 8'h00);

    // Same draw erases and collides
    draw(12'h200, 8'd0, 8'd0, 4'd1, lat);
    check("t2_coll", collision, 1);
    check("t2_fb00", fb[8'h00], 8'h00);

    // Byte-straddling draw
    w0 = fbw_cnt;
    draw(12'h210, 8'd13, 8'd2, 4'd1, lat);
    check("t3_coll", collision, 0);
    check("t3_fb11", fb[8'h11], 8'h07);
    check("t3_fb12", fb[8'h12], 8'hF8);
    check("t3_writes", fbw_cnt - w0, 2);

    // X and Y wrap / clip
    draw(12'h220, 8'h3E, 8'd31, 4'd2, lat);
    check("t4_lat", lat, 11);
    check("t4_fbFF", fb[8'hFF], 8'h03);
`ifdef SPRITE_CLIP_EN
    check("t4_fbF8", fb[8'hF8], 8'h00);
    check("t4_fb07", fb[8'h07], 8'h00);
    check("t4_fb00", fb[8'h00], 8'h00);
`else
    check("t4_fbF8", fb[8'hF8], 8'h0C);
    check("t4_fb07", fb[8'h07], 8'h03);
    check("t4_fb00", fb[8'h00], 8'h0C);
`endif
    check("t4_coll", collision, 0);

    // n=0
    m0 = mem_cnt; e0 = fben_cnt;
    draw(12'h200, 8'd5, 8'd5, 4'd0, lat);
    check("t5_lat", lat, 1);
    check("t5_coll", collision, 0);
    check("t5_mem", mem_cnt - m0, 0);
    check("t5_fben", fben_cnt - e0, 0);

    // Start pulse while busy is ignored
    @(negedge clk);
    i_addr = 12'h230; vx = 8'd0; vy = 8'd9; n = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    @(negedge clk);
    lat++;
    n = 4'd0; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("t6_lat", lat, 6);
    check("t6_coll", collision, 0);
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("t6_extra_done", done_cnt - d0, 1);
    check("t6_idle", busy, 0);

    // Memory address wrap
    draw(12'hFFF, 8'd0, 8'd10, 4'd2, lat);
    check("t7_fb50", fb[8'h50], 8'h80);
    check("t7_fb58", fb[8'h58], 8'h01);

    // Reset during WRL of row 1
    @(negedge clk);
    i_addr = 12'h240; vx = 8'd0; vy = 8'd20; n = 4'd3; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t8_wrl_write", fb_write, 1);
    check("t8_wrl_addr", fb_addr, 8'hA8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t8_busy", busy, 0);
    w0 = fbw_cnt; d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("t8_no_write", fbw_cnt - w0, 0);
    check("t8_no_done", done_cnt - d0, 0);
    check("t8_fbA0", fb[8'hA0], 8'hAA);

    draw(12'h200, 8'd8, 8'd5, 4'd1, lat);
    check("t9_lat", lat, 6);
    check("t9_fb29", fb[8'h29], 8'hF0);
    check("t9_coll", collision, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
